// File: rtl/heston_path_sequencer.sv
// heston_path_sequencer: drives one double_core Monte-Carlo engine through its
// reset / seed-load / kick sequence, waits out the pipeline fill, then counts
// steps and paths on the free-running price stream and captures the terminal
// Price1/Price2 of every path.
// Optional feature macro: HESTON_SEQ_STEP_STREAM_EN adds step_valid/step_idx.
module heston_path_sequencer #(
    parameter int unsigned STEPS_PER_PATH = 1464,
    parameter int unsigned LAUNCH_LAT     = 6,
    parameter int unsigned PATH_W         = 16,
    parameter int unsigned STEP_W         = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PATH_W-1:0] num_paths,
    input  logic [31:0]       price1_in,
    input  logic [31:0]       price2_in,
    output logic              core_rst,
    output logic              core_en,
    output logic              busy,
    output logic              done,
    output logic              aborted,
`ifdef HESTON_SEQ_STEP_STREAM_EN
    output logic              step_valid,
    output logic [STEP_W-1:0] step_idx,
`endif
    output logic              path_valid,
    output logic [31:0]       path_price1,
    output logic [31:0]       path_price2,
    output logic [PATH_W-1:0] path_idx
);

    // Phase counter covers both the 2-cycle LOAD and the LAUNCH_LAT-cycle WAIT.
    localparam int unsigned CNT_W = (LAUNCH_LAT < 3) ? 1 : $clog2(LAUNCH_LAT);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_LOAD, S_KICK, S_WAIT, S_RUN, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    phase_cnt, phase_nxt;
    logic [STEP_W-1:0]   step_cnt, step_nxt;
    logic [PATH_W-1:0]   path_cnt, path_nxt;
    logic [PATH_W-1:0]   num_q;
    logic                ab_flag, ab_nxt;
    logic                accept, capture, done_nxt, aborted_nxt;

    // State, counters and run bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            step_cnt  <= '0;
            path_cnt  <= '0;
            num_q     <= '0;
            ab_flag   <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            step_cnt  <= step_nxt;
            path_cnt  <= path_nxt;
            ab_flag   <= ab_nxt;
            if (accept) num_q <= num_paths;
        end
    end

    // Next-state, counter and strobe decode; abort overrides everything after IDLE.
    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase_cnt;
        step_nxt    = step_cnt;
        path_nxt    = path_cnt;
        ab_nxt      = ab_flag;
        accept      = 1'b0;
        capture     = 1'b0;
        done_nxt    = 1'b0;
        aborted_nxt = aborted;
        case (state)
            S_IDLE: begin
                if (start) begin
                    aborted_nxt = 1'b0;
                    ab_nxt      = 1'b0;
                    if (num_paths != '0) begin
                        accept    = 1'b1;
                        state_nxt = S_RST;
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end
            end
            S_RST: begin
                phase_nxt = '0;
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (phase_cnt == CNT_W'(1)) begin
                    phase_nxt = '0;
                    state_nxt = S_KICK;
                end else begin
                    phase_nxt = phase_cnt + CNT_W'(1);
                end
            end
            S_KICK: begin
                phase_nxt = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (phase_cnt == CNT_W'(LAUNCH_LAT - 1)) begin
                    phase_nxt = '0;
                    step_nxt  = '0;
                    path_nxt  = '0;
                    state_nxt = S_RUN;
                end else begin
                    phase_nxt = phase_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (step_cnt == STEP_W'(STEPS_PER_PATH - 1)) begin
                    capture  = 1'b1;
                    step_nxt = '0;
                    path_nxt = path_cnt + PATH_W'(1);
                    if (path_cnt == num_q - PATH_W'(1)) state_nxt = S_DONE;
                end else begin
                    step_nxt = step_cnt + STEP_W'(1);
                end
            end
            S_DONE: begin
                done_nxt    = 1'b1;
                aborted_nxt = ab_flag;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE && state != S_DONE) begin
            state_nxt = S_DONE;
            capture   = 1'b0;
            ab_nxt    = 1'b1;
        end
    end

    // Registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rst    <= 1'b1;
            core_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            path_valid  <= 1'b0;
            path_price1 <= '0;
            path_price2 <= '0;
            path_idx    <= '0;
        end else begin
            core_rst   <= !(state_nxt == S_KICK || state_nxt == S_WAIT || state_nxt == S_RUN);
            core_en    <= (state_nxt == S_LOAD || state_nxt == S_KICK);
            busy       <= (state_nxt != S_IDLE);
            done       <= done_nxt;
            aborted    <= aborted_nxt;
            path_valid <= capture;
            if (capture) begin
                path_price1 <= price1_in;
                path_price2 <= price2_in;
                path_idx    <= path_cnt;
            end
        end
    end

`ifdef HESTON_SEQ_STEP_STREAM_EN
    // Per-step strobe: high for every RUN cycle, carrying that cycle's step count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_valid <= 1'b0;
            step_idx   <= '0;
        end else begin
            step_valid <= (state_nxt == S_RUN);
            step_idx   <= (state_nxt == S_RUN) ? step_nxt : '0;
        end
    end
`endif

endmodule
